// File: rtl/fp_div_sequencer.sv
// fp_div_sequencer
//   Computes a/b as a*(1/b) by sequencing an external combinational FP
//   reciprocal and FP multiplier. IEEE-754 single special cases (NaN, 0/0,
//   inf/inf, x/0) are resolved here without using the datapath.
//   One operation in flight; valid/ready handshake on both sides.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready high only in IDLE
//   a, b                dividend / divisor
//   out_valid/out_ready result handshake
//   q                   quotient
//   div_by_zero         nonzero non-NaN a divided by zero
//   invalid             NaN result produced
//   busy                sequencer not idle
//   recip_x / recip_y   reciprocal operand (registered) / result
//   mul_a, mul_b/mul_p  multiplier operands (registered) / product
module fp_div_sequencer #(
  parameter int unsigned RECIP_LAT = 1,
  parameter int unsigned MUL_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        busy,
  output logic [31:0] recip_x,
  input  logic [31:0] recip_y,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p
);

  localparam int unsigned MAX_LAT = (RECIP_LAT > MUL_LAT) ? RECIP_LAT : MUL_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECIP = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic        dbz_q, dbz_d;
  logic        inv_q, inv_d;
  logic [31:0] recip_x_q, recip_x_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;

  // Operand classification
  logic a_exp_max, b_exp_max, a_man_zero, b_man_zero;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic spec_hit, spec_dbz, spec_inv;
  logic [31:0] spec_q;
  logic accept;

  always_comb begin
    a_exp_max  = (a[30:23] == 8'hFF);
    b_exp_max  = (b[30:23] == 8'hFF);
    a_man_zero = (a[22:0] == 23'd0);
    b_man_zero = (b[22:0] == 23'd0);
    a_nan      = a_exp_max & ~a_man_zero;
    b_nan      = b_exp_max & ~b_man_zero;
    a_inf      = a_exp_max &  a_man_zero;
    b_inf      = b_exp_max &  b_man_zero;
    a_zero     = (a[30:0] == 31'd0);
    b_zero     = (b[30:0] == 31'd0);

    spec_inv = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    spec_dbz = ~spec_inv & b_zero;
    spec_hit = spec_inv | spec_dbz;
    spec_q   = spec_inv ? QNAN : {a[31] ^ b[31], INF_MAG};
  end

  assign accept = (state_q == S_IDLE) & in_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (spec_hit) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RECIP;
            cnt_d   = CW'(RECIP_LAT - 1);
          end
        end
      end
      S_RECIP: begin
        if (cnt_q == '0) begin
          state_d = S_MUL;
          cnt_d   = CW'(MUL_LAT - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      dbz_q     <= 1'b0;
      inv_q     <= 1'b0;
      recip_x_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      dbz_q     <= dbz_d;
      inv_q     <= inv_d;
      recip_x_q <= recip_x_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  // mul_b doubles as the latched reciprocal result; no separate copy is kept.
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    dbz_d     = dbz_q;
    inv_d     = inv_q;
    recip_x_d = recip_x_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;

    if (accept) begin
      a_d = a;
      if (spec_hit) begin
        q_d   = spec_q;
        dbz_d = spec_dbz;
        inv_d = spec_inv;
      end else begin
        recip_x_d = b;
      end
    end

    if ((state_q == S_RECIP) && (cnt_q == '0)) begin
      mul_a_d = a_q;
      mul_b_d = recip_y;
    end

    if ((state_q == S_MUL) && (cnt_q == '0)) begin
      q_d   = mul_p;
      dbz_d = 1'b0;
      inv_d = 1'b0;
    end

    if ((state_q == S_DONE) && out_ready) begin
      dbz_d = 1'b0;
      inv_d = 1'b0;
    end
  end

  assign q           = q_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;
  assign recip_x     = recip_x_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;

endmodule
